// File: rtl/qid_instbuf.sv
// qid_instbuf -- first-word-fall-through instruction buffer feeding the QID decoder.
//
// Accepts instructions from the fetch/host side and presents the head entry to the decoder
// without a read request: the opcode field on temp_opcode, the full word on head_inst.
// The head entry is opaque. An entry such as LQM_FB simply stays at the head until
// downstream asserts pop.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            synchronous clear of all entries (error flags are kept)
//   in_valid/in_inst write request and instruction word; in_ready = !instbuf_full
//   pop              downstream consumed the head entry this cycle
//   temp_opcode      opcode of head entry, `INVALID_OPCODE while empty
//   head_inst        full head entry, zero while empty
//   instbuf_empty/instbuf_full/count   occupancy status
//   err_overflow/err_underflow         sticky misuse flags
//
// Optional feature macro: QID_INSTBUF_ERR_EN. When it is defined, the sticky error flags
// are implemented. When it is undefined, both flags are tied to zero.

`ifndef OPCODE_BW
`define OPCODE_BW 8
`endif
`ifndef INVALID_OPCODE
`define INVALID_OPCODE {`OPCODE_BW{1'b1}}
`endif

module qid_instbuf #(
    parameter int INST_BW = 64,
    parameter int DEPTH   = 16,
    parameter int PTR_BW  = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [INST_BW-1:0]    in_inst,
    output logic                  in_ready,
    input  logic                  pop,
    output logic [`OPCODE_BW-1:0] temp_opcode,
    output logic [INST_BW-1:0]    head_inst,
    output logic                  instbuf_empty,
    output logic                  instbuf_full,
    output logic [PTR_BW:0]       count,
    output logic                  err_overflow,
    output logic                  err_underflow
);

    localparam logic [PTR_BW-1:0] PTR_ONE   = PTR_BW'(1);
    localparam logic [PTR_BW:0]   CNT_ONE   = (PTR_BW + 1)'(1);
    localparam logic [PTR_BW:0]   CNT_DEPTH = (PTR_BW + 1)'(DEPTH);

    logic [INST_BW-1:0] mem [DEPTH];
    logic [PTR_BW-1:0]  rd_ptr;
    logic [PTR_BW-1:0]  wr_ptr;
    logic [PTR_BW:0]    count_r;
    logic [PTR_BW:0]    count_nxt;
    logic               empty_r;
    logic               full_r;
    logic               push;
    logic               popv;
    logic [INST_BW-1:0] head_raw;

    // in_ready comes from registered state only, so a full buffer never writes through
    // even when the head is being popped in the same cycle.
    assign in_ready = ~full_r;
    assign push     = in_valid & in_ready;
    assign popv     = pop & ~empty_r;

    always_comb begin
        count_nxt = count_r;
        if (flush) begin
            count_nxt = '0;
        end else if (push && !popv) begin
            count_nxt = count_r + CNT_ONE;
        end else if (popv && !push) begin
            count_nxt = count_r - CNT_ONE;
        end
    end

    // Control state: pointers, occupancy and the flags derived from next-state count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_r <= '0;
            empty_r <= 1'b1;
            full_r  <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_ONE;
                if (popv) rd_ptr <= rd_ptr + PTR_ONE;
            end
            count_r <= count_nxt;
            empty_r <= (count_nxt == '0);
            full_r  <= (count_nxt == CNT_DEPTH);
        end
    end

    // Storage is not reset. Pointers and count alone decide what is valid. A push that
    // coincides with flush or rst is discarded.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= in_inst;
        end
    end

    assign head_raw      = mem[rd_ptr];
    assign head_inst     = empty_r ? '0 : head_raw;
    assign temp_opcode   = empty_r ? `INVALID_OPCODE : head_raw[INST_BW-1 -: `OPCODE_BW];
    assign instbuf_empty = empty_r;
    assign instbuf_full  = full_r;
    assign count         = count_r;

`ifdef QID_INSTBUF_ERR_EN
    logic ovf_r;
    logic udf_r;

    // The flags are sticky until rst. A flush does not clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (in_valid && full_r) ovf_r <= 1'b1;
            if (pop && empty_r)     udf_r <= 1'b1;
        end
    end

    assign err_overflow  = ovf_r;
    assign err_underflow = udf_r;
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif

endmodule
